mmu_cache_ctrl_mp: RTL and testbench

Parametrised multi-port request/response controller between the MMU and its caches (I-cache, D-cache, further walker/L2 ports). Each of `NPORT` independent channels gates read/write requests on the cache's registered availability. It tracks one outstanding access per channel with a small FSM and generates a one-cycle completion strobe. Minimum read/write latencies are enforced per channel, and a hung access is aborted by a watchdog.

---
 rtl/mmu_cache_ctrl_mp_if.sv | 28 ++
 rtl/mmu_cache_ctrl_mp.sv | 134 +++++++++++++
 tb/tb_mmu_cache_ctrl_mp.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_cache_ctrl_mp_if.sv
// Bundle of per-channel request/response signals between the MMU, the
// controller and the caches. Each vector bit is one independent channel.
interface mmu_cache_ctrl_mp_if #(
   parameter int NPORT = 2
);
   logic [NPORT-1:0] req_rd_i;
   logic [NPORT-1:0] req_wr_i;
   logic [NPORT-1:0] cache_avail_i;
   logic [NPORT-1:0] err_clr_i;
   logic [NPORT-1:0] cache_rd_o;
   logic [NPORT-1:0] cache_wr_o;
   logic [NPORT-1:0] valid_o;
   logic [NPORT-1:0] busy_o;
   logic [NPORT-1:0] timeout_o;
   logic [NPORT-1:0] err_o;

   // MMU/cache side: drives requests and availability, observes the gated results
   modport master (
      output req_rd_i, req_wr_i, cache_avail_i, err_clr_i,
      input  cache_rd_o, cache_wr_o, valid_o, busy_o, timeout_o, err_o
   );

   // Controller side
   modport slave (
      input  req_rd_i, req_wr_i, cache_avail_i, err_clr_i,
      output cache_rd_o, cache_wr_o, valid_o, busy_o, timeout_o, err_o
   );
endinterface

// File: rtl/mmu_cache_ctrl_mp.sv
// Multi-port MMU/cache request controller: one outstanding access per channel,
// minimum read/write latency enforcement and a per-channel watchdog abort.
module mmu_cache_ctrl_mp #(
   parameter int NPORT      = 2,
   parameter int RD_MIN_LAT = 1,
   parameter int WR_MIN_LAT = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   mmu_cache_ctrl_mp_if.slave     bus
);

   localparam int LAT_RW  = (RD_MIN_LAT > WR_MIN_LAT) ? RD_MIN_LAT : WR_MIN_LAT;
   localparam int LAT_MAX = (LAT_RW > TIMEOUT) ? LAT_RW : TIMEOUT;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);
   localparam int TO_LIM  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam bit TO_EN   = (TIMEOUT != 0);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_THR  = CNT_W'(TO_LIM);
   // Latencies are compared against cnt+1 so a latency of 1 never becomes a
   // trivially-true "cnt >= 0" test.
   localparam logic [CNT_W:0]   RD_LAT  = (CNT_W+1)'(RD_MIN_LAT);
   localparam logic [CNT_W:0]   WR_LAT  = (CNT_W+1)'(WR_MIN_LAT);
   localparam logic [CNT_W:0]   ONE_EXT = (CNT_W+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } state_t;

   logic [NPORT-1:0] w_cacheRdV;
   logic [NPORT-1:0] w_cacheWrV;
   logic [NPORT-1:0] w_validV;
   logic [NPORT-1:0] w_busyV;
   logic [NPORT-1:0] w_timeoutV;
   logic [NPORT-1:0] w_errV;

   for (genvar p = 0; p < NPORT; p++) begin : g_chan
      state_t           r_state;
      state_t           w_stateNxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cntNxt;
      logic             r_availQ;
      logic             r_err;
      logic             w_wait;
      logic             w_latMet;
      logic             w_resp;
      logic             w_tmo;
      logic             w_wrFwd;
      logic             w_rdFwd;
      logic             w_valid;
      logic             w_timeout;
      logic             w_busy;
      logic             w_cacheRd;
      logic             w_cacheWr;

      // Write wins over a simultaneous read; the read stays pending in the MMU.
      assign w_wait   = (r_state != ST_IDLE);
      assign w_wrFwd  = (r_state == ST_IDLE) & bus.req_wr_i[p] & r_availQ;
      assign w_rdFwd  = (r_state == ST_IDLE) & bus.req_rd_i[p] & ~bus.req_wr_i[p] & r_availQ;
      assign w_latMet = (r_state == ST_WR_WAIT) ? (({1'b0, r_cnt} + ONE_EXT) >= WR_LAT)
                                                : (({1'b0, r_cnt} + ONE_EXT) >= RD_LAT);
      assign w_resp   = w_wait & bus.cache_avail_i[p] & r_availQ & w_latMet;
      assign w_tmo    = TO_EN & w_wait & ~w_resp & (r_cnt == TO_THR);

      // Error flag is set-dominant over the clear request.
      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_availQ <= 1'b1;
            r_err    <= 1'b0;
         end else begin
            r_state  <= w_stateNxt;
            r_cnt    <= w_cntNxt;
            r_availQ <= bus.cache_avail_i[p];
            r_err    <= w_tmo | (r_err & ~bus.err_clr_i[p]);
         end
      end

      always_comb begin
         w_stateNxt = r_state;
         w_cntNxt   = r_cnt;
         case (r_state)
            ST_IDLE: begin
               if (w_wrFwd) begin
                  w_stateNxt = ST_WR_WAIT;
                  w_cntNxt   = '0;
               end else if (w_rdFwd) begin
                  w_stateNxt = ST_RD_WAIT;
                  w_cntNxt   = '0;
               end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
               if (w_resp || w_tmo) begin
                  w_stateNxt = ST_IDLE;
               end else if (r_cnt != CNT_MAX) begin
                  w_cntNxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_stateNxt = ST_IDLE;
               w_cntNxt   = '0;
            end
         endcase
      end

      always_comb begin
         w_valid   = w_resp;
         w_timeout = w_tmo;
         w_busy    = w_wait;
         w_cacheRd = w_rdFwd;
         w_cacheWr = w_wrFwd;
      end

      assign w_cacheRdV[p] = w_cacheRd;
      assign w_cacheWrV[p] = w_cacheWr;
      assign w_validV[p]   = w_valid;
      assign w_busyV[p]    = w_busy;
      assign w_timeoutV[p] = w_timeout;
      assign w_errV[p]     = r_err;
   end

   assign bus.cache_rd_o = w_cacheRdV;
   assign bus.cache_wr_o = w_cacheWrV;
   assign bus.valid_o    = w_validV;
   assign bus.busy_o     = w_busyV;
   assign bus.timeout_o  = w_timeoutV;
   assign bus.err_o      = w_errV;

endmodule

// File: tb/tb_mmu_cache_ctrl_mp.sv
// Scenario bench for mmu_cache_ctrl_mp: per-cycle expected output vectors are
// queued as stimulus is applied and popped when the outputs are sampled.
module tb_mmu_cache_ctrl_mp;

   logic clock;
   logic rstN;
   int   vectors;
   int   miscompares;
   logic [11:0] sbq[$];

   mmu_cache_ctrl_mp_if #(.NPORT(2)) bus ();

   mmu_cache_ctrl_mp #(
      .NPORT      (2),
      .RD_MIN_LAT (1),
      .WR_MIN_LAT (2),
      .TIMEOUT    (8)
   ) dut (
      .clk_i (clock),
      .rst_i (rstN),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observed outputs packed as {timeout, err, valid, busy, cache_wr, cache_rd}
   function automatic logic [11:0] obs();
      return {bus.timeout_o, bus.err_o, bus.valid_o, bus.busy_o, bus.cache_wr_o, bus.cache_rd_o};
   endfunction

   function automatic logic [11:0] ev(input logic [1:0] to, input logic [1:0] er,
                                      input logic [1:0] va, input logic [1:0] bu,
                                      input logic [1:0] wr, input logic [1:0] rd);
      return {to, er, va, bu, wr, rd};
   endfunction

   task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                                input logic [1:0] av, input logic [1:0] clr);
      bus.req_rd_i      = rd;
      bus.req_wr_i      = wr;
      bus.cache_avail_i = av;
      bus.err_clr_i     = clr;
   endtask

   task automatic test_reset();
      logic [11:0] e, got;
      applyStimulus(2'b00, 2'b00, 2'b11, 2'b00);
      sbq.push_back(ev(0, 0, 0, 0, 0, 0));
      @(negedge clock);
      got = obs(); e = sbq.pop_front(); vectors++;
      if (got !== e) begin
         miscompares++;
         $display("[TB] FAIL reset_held: got %03h expected %03h", got, e);
      end
      @(posedge clock); #1;
      rstN = 1'b1;
      sbq.push_back(ev(0, 0, 0, 0, 0, 0));
      @(negedge clock);
      got = obs(); e = sbq.pop_front(); vectors++;
      if (got !== e) begin
         miscompares++;
         $display("[TB] FAIL reset_release: got %03h expected %03h", got, e);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_read_hit();
      logic [11:0] e, got;
      for (int k = 0; k < 4; k++) begin
         applyStimulus((k == 0) ? 2'b01 : 2'b00, 2'b00, 2'b11, 2'b00);
         case (k)
            0:       sbq.push_back(ev(0, 0, 0, 0, 0, 2'b01));
            1:       sbq.push_back(ev(0, 0, 2'b01, 2'b01, 0, 0));
            default: sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         endcase
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL read_hit cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_write_miss();
      logic [11:0] e, got;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(2'b00, (k == 0) ? 2'b01 : 2'b00,
                       (k >= 1 && k <= 4) ? 2'b10 : 2'b11, 2'b00);
         if (k == 0)      sbq.push_back(ev(0, 0, 0, 0, 2'b01, 0));
         else if (k <= 5) sbq.push_back(ev(0, 0, 0, 2'b01, 0, 0));
         else if (k == 6) sbq.push_back(ev(0, 0, 2'b01, 2'b01, 0, 0));
         else             sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL write_miss cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_rd_wr_priority();
      logic [11:0] e, got;
      for (int k = 0; k < 6; k++) begin
         applyStimulus((k <= 3) ? 2'b01 : 2'b00, (k <= 2) ? 2'b01 : 2'b00, 2'b11, 2'b00);
         case (k)
            0:       sbq.push_back(ev(0, 0, 0, 0, 2'b01, 0));
            1:       sbq.push_back(ev(0, 0, 0, 2'b01, 0, 0));
            2:       sbq.push_back(ev(0, 0, 2'b01, 2'b01, 0, 0));
            3:       sbq.push_back(ev(0, 0, 0, 0, 0, 2'b01));
            4:       sbq.push_back(ev(0, 0, 2'b01, 2'b01, 0, 0));
            default: sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         endcase
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL rd_wr_priority cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_watchdog();
      logic [11:0] e, got;
      // Read never answered: abort after 8 cycles, sticky error until cleared
      for (int k = 0; k < 14; k++) begin
         applyStimulus((k == 0) ? 2'b01 : 2'b00, 2'b00,
                       (k >= 1 && k <= 11) ? 2'b10 : 2'b11,
                       (k == 12) ? 2'b01 : 2'b00);
         if (k == 0)       sbq.push_back(ev(0, 0, 0, 0, 0, 2'b01));
         else if (k <= 7)  sbq.push_back(ev(0, 0, 0, 2'b01, 0, 0));
         else if (k == 8)  sbq.push_back(ev(2'b01, 0, 0, 2'b01, 0, 0));
         else if (k <= 12) sbq.push_back(ev(0, 2'b01, 0, 0, 0, 0));
         else              sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL watchdog_abort cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
      // Response lands exactly on the watchdog cycle: completion must win
      for (int k = 0; k < 10; k++) begin
         applyStimulus((k == 0) ? 2'b01 : 2'b00, 2'b00,
                       (k >= 1 && k <= 6) ? 2'b10 : 2'b11, 2'b00);
         if (k == 0)      sbq.push_back(ev(0, 0, 0, 0, 0, 2'b01));
         else if (k <= 7) sbq.push_back(ev(0, 0, 0, 2'b01, 0, 0));
         else if (k == 8) sbq.push_back(ev(0, 0, 2'b01, 2'b01, 0, 0));
         else             sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL watchdog_race cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_parallel();
      logic [11:0] e, got;
      for (int k = 0; k < 6; k++) begin
         applyStimulus((k == 0) ? 2'b01 : 2'b00,
                       (k == 0) ? 2'b10 : ((k == 2) ? 2'b01 : 2'b00),
                       (k == 1) ? 2'b01 : 2'b11, 2'b00);
         case (k)
            0:       sbq.push_back(ev(0, 0, 0, 0, 2'b10, 2'b01));
            1:       sbq.push_back(ev(0, 0, 2'b01, 2'b11, 0, 0));
            2:       sbq.push_back(ev(0, 0, 0, 2'b10, 2'b01, 0));
            3:       sbq.push_back(ev(0, 0, 2'b10, 2'b11, 0, 0));
            4:       sbq.push_back(ev(0, 0, 2'b01, 2'b01, 0, 0));
            default: sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         endcase
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL parallel cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] e, got;
      for (int k = 0; k < 5; k++) begin
         applyStimulus((k <= 3) ? 2'b10 : 2'b00, 2'b00, 2'b11, 2'b00);
         case (k)
            0, 2:    sbq.push_back(ev(0, 0, 0, 0, 0, 2'b10));
            1, 3:    sbq.push_back(ev(0, 0, 2'b10, 2'b10, 0, 0));
            default: sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         endcase
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL back_to_back cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset_mid_access();
      logic [11:0] e, got;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            applyStimulus(2'b00, 2'b01, 2'b11, 2'b00);
            sbq.push_back(ev(0, 0, 0, 0, 2'b01, 0));
            @(negedge clock);
         end else if (k == 1) begin
            applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
            sbq.push_back(ev(0, 0, 0, 2'b01, 0, 0));
            @(negedge clock);
         end else begin
            #2 rstN = 1'b0;
            sbq.push_back(ev(0, 0, 0, 0, 0, 0));
            #1;
         end
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL reset_mid cyc%0d: got %03h expected %03h", k, got, e);
         end
         if (k < 2) begin
            @(posedge clock); #1;
         end
      end
      @(posedge clock); #1;
      rstN = 1'b1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus((k == 1) ? 2'b01 : 2'b00, 2'b00, 2'b11, 2'b00);
         case (k)
            1:       sbq.push_back(ev(0, 0, 0, 0, 0, 2'b01));
            2:       sbq.push_back(ev(0, 0, 2'b01, 2'b01, 0, 0));
            default: sbq.push_back(ev(0, 0, 0, 0, 0, 0));
         endcase
         @(negedge clock);
         got = obs(); e = sbq.pop_front(); vectors++;
         if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL after_reset cyc%0d: got %03h expected %03h", k, got, e);
         end
         @(posedge clock); #1;
      end
   endtask

   // Runs every scenario in order, then reports
   initial begin
      vectors     = 0;
      miscompares = 0;
      rstN        = 1'b0;
      applyStimulus(2'b00, 2'b00, 2'b11, 2'b00);
      repeat (2) @(posedge clock);
      #1;
      test_reset();
      test_read_hit();
      test_write_miss();
      test_rd_wr_priority();
      test_watchdog();
      test_parallel();
      test_back_to_back();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Guards against a stuck run
   initial begin
      #100000;
      $display("[TB] FAIL sim_timeout: got no finish, required finish before 100000");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

endmodule
